// File: rtl/pe_pass_scheduler.sv
// pe_pass_scheduler: lets NUM_REQ requesters share one PE using round-robin arbitration.
//   Each granted job runs PASSES back-to-back PE passes, one per filter row, so psums
//   accumulate across passes. The owner then gets a completion response.
// Latency: req to gnt/pe_en is 1 cycle. The next pass launches 1 cycle after pe_done.
//   rsp_valid rises 1 cycle after the last pe_done. The earliest next job starts 2 cycles
//   after the response handshake.
// Backpressure: in RESP, rsp_valid/rsp_id and gnt are held and the PE stays idle until
//   rsp_ready is seen.
// Ports:
//   clk, rst                        - clock; synchronous active-high reset
//   req[NUM_REQ]                    - level requests
//   gnt / sel                       - one-hot and binary owner; they steer the external
//                                     FILTER/DATA/PSUM input muxes
//   pass_idx, pe_en, pe_done        - filter-row select, PE start pulse, PE done pulse
//   rsp_valid/rsp_id/rsp_err/rsp_ready - completion response handshake
//   busy                            - high whenever the scheduler is not IDLE
// Option macro PE_TIMEOUT_EN:
//   When defined, a WAIT watchdog of TIMEOUT_CYCLES cycles abandons the job and returns
//   rsp_err=1. When undefined, rsp_err is tied low and WAIT waits indefinitely.
module pe_pass_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int PASSES         = 3,
   parameter int SEL_W          = $clog2(NUM_REQ),
   parameter int PASS_W         = (PASSES > 1) ? $clog2(PASSES) : 1,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic [PASS_W-1:0]  pass_idx,
   output logic               pe_en,
   input  logic               pe_done,
   output logic               rsp_valid,
   output logic [SEL_W-1:0]   rsp_id,
   output logic               rsp_err,
   input  logic               rsp_ready,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   localparam logic [SEL_W:0]    NUM_REQ_X = (SEL_W+1)'(NUM_REQ);
   localparam logic [SEL_W-1:0]  LAST_REQ  = SEL_W'(NUM_REQ - 1);
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

   state_t               state_q;
   logic [SEL_W-1:0]     ptr_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [SEL_W-1:0]     sel_q;
   logic [PASS_W-1:0]    pass_q;
   logic                 pe_en_q;
   logic                 rsp_valid_q;
   logic [SEL_W-1:0]     rsp_id_q;
   logic                 busy_q;

`ifdef PE_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q;
   logic             rsp_err_q;
`endif

   // Round-robin pick. The scan runs from the farthest offset back toward ptr, so the
   // last hit written is the first set bit at or above ptr, wrapping modulo NUM_REQ.
   logic             pick_vld_d;
   logic [SEL_W-1:0] pick_idx_d;
   logic [SEL_W:0]   cand;
   always_comb begin
      pick_vld_d = 1'b0;
      pick_idx_d = '0;
      cand       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
         if (cand >= NUM_REQ_X) cand = cand - NUM_REQ_X;
         if (req[cand[SEL_W-1:0]]) begin
            pick_vld_d = 1'b1;
            pick_idx_d = cand[SEL_W-1:0];
         end
      end
   end

   // The pointer moves just past the owner that was served, so that owner drops to
   // lowest priority for the next pick.
   logic [SEL_W-1:0] ptr_d;
   assign ptr_d = (sel_q == LAST_REQ) ? '0 : sel_q + SEL_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         sel_q       <= '0;
         pass_q      <= '0;
         pe_en_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         busy_q      <= 1'b0;
`ifdef PE_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_vld_d) begin
                  state_q <= S_LAUNCH;
                  gnt_q   <= NUM_REQ'(1) << pick_idx_d;
                  sel_q   <= pick_idx_d;
                  pass_q  <= '0;
                  pe_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_LAUNCH: begin
               // pe_done is deliberately not looked at here. The PE cannot finish in
               // the same cycle it is started.
               state_q <= S_WAIT;
               pe_en_q <= 1'b0;
`ifdef PE_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            S_WAIT: begin
               if (pe_done) begin
                  if (pass_q == LAST_PASS) begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_id_q    <= sel_q;
`ifdef PE_TIMEOUT_EN
                     rsp_err_q   <= 1'b0;
`endif
                  end else begin
                     pass_q  <= pass_q + PASS_W'(1);
                     state_q <= S_LAUNCH;
                     pe_en_q <= 1'b1;
                  end
               end
`ifdef PE_TIMEOUT_EN
               else if (cnt_q == CNT_LAST) begin
                  // TIMEOUT_CYCLES WAIT cycles have passed with no done.
                  // Abandon the remaining passes and report an error.
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= sel_q;
                  rsp_err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_q     <= S_IDLE;
                  gnt_q       <= '0;
                  rsp_valid_q <= 1'b0;
                  ptr_q       <= ptr_d;
                  busy_q      <= 1'b0;
`ifdef PE_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign pass_idx  = pass_q;
   assign pe_en     = pe_en_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = busy_q;
`ifdef PE_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pe_pass_scheduler.sv
// tb_pe_pass_scheduler: randomized and directed stimulus for pe_pass_scheduler, with
//   NUM_REQ=4 and PASSES=3. Expected behaviour comes from a job-level timeline model
//   plus a round-robin pick function.
// The PE model pulses pe_done pe_lat cycles after each pe_en. Inputs are driven 1 time
//   unit after the rising edge, and outputs are sampled at that same point.
module tb_pe_pass_scheduler;
   localparam int N  = 4;
   localparam int P  = 3;
   localparam int SW = 2;
   localparam int PW = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [SW-1:0] sel;
   logic [PW-1:0] pass_idx;
   logic         pe_en;
   logic         pe_done;
   logic         rsp_valid;
   logic [SW-1:0] rsp_id;
   logic         rsp_err;
   logic         rsp_ready;
   logic         busy;

   pe_pass_scheduler #(.NUM_REQ(N), .PASSES(P)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .pass_idx(pass_idx),
      .pe_en(pe_en), .pe_done(pe_done), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;
   int ptr_m       = 0;   // model round-robin pointer

   // PE model: a done pulse pe_lat cycles after each observed pe_en.
   int   pe_lat  = 7;
   bit   pe_mute = 1'b0;
   int   pe_due  = -1;
   logic pe_done_m = 1'b0;
   logic pe_inj    = 1'b0;
   assign pe_done = pe_done_m | pe_inj;
   always @(posedge clk) begin
      #2;
      if (rst) pe_due = -1;
      else if (pe_en && !pe_mute) pe_due = cyc + pe_lat;
      pe_done_m = (cyc == pe_due);
   end

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      logic [N-1:0] s;
      for (int k = 0; k < N; k++) begin
         s = r >> ((p + k) % N);
         if (s[0]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete job. The requester drives pat at cycle t. The expected waveform is:
   // launch k at t+1+k*(lat+1), response at r=t+1+P*(lat+1), handshake at h=r+stall.
   task automatic run_job(input logic [N-1:0] pat, input int lat, input int stall,
                          input bit drop, input bit spur);
      int o, t, r, h, d, k;
      logic [N-1:0] e_gnt;
      logic [N+2:0] obs, exp_v;
      logic         en_e;
      o      = rr_pick(pat, ptr_m);
      e_gnt  = N'(1) << o;
      pe_lat = lat;
      rsp_ready = 1'b1;
      req    = pat;
      t      = cyc;
      r      = t + 1 + P * (lat + 1);
      h      = r + stall;
      for (int c = t + 1; c <= h + 2; c++) begin
         step();
         rsp_ready = !(c >= r && c < h);
         pe_inj    = spur && (c == t + 1 || c == r);
         if (drop && c == t + 1 + (lat + 1)) req = req & ~(N'(1) << o);
         if (c == h + 1) req = '0;
         obs = {gnt, pe_en, rsp_valid, busy};
         if (c <= h) begin
            d     = c - (t + 1);
            k     = d / (lat + 1);
            en_e  = (c < r) && (d % (lat + 1) == 0);
            exp_v = {e_gnt, en_e, (c >= r), 1'b1};
            vectors++;
            if (obs !== exp_v) begin
               miscompares++;
               $display("FAIL job_ctl c+%0d gnt/en/valid/busy got %b want %b", c - t, obs, exp_v);
            end
            vectors++;
            if (sel !== SW'(o)) begin
               miscompares++;
               $display("FAIL job_sel c+%0d got %0d want %0d", c - t, sel, o);
            end
            if (c < r) begin
               vectors++;
               if (pass_idx !== PW'(k)) begin
                  miscompares++;
                  $display("FAIL job_pass c+%0d got %0d want %0d", c - t, pass_idx, k);
               end
            end else begin
               vectors++;
               if ({rsp_id, rsp_err} !== {SW'(o), 1'b0}) begin
                  miscompares++;
                  $display("FAIL job_rsp c+%0d id/err got %0d/%b want %0d/0", c - t, rsp_id, rsp_err, o);
               end
            end
         end else begin
            vectors++;
            if ({obs, rsp_err} !== '0) begin
               miscompares++;
               $display("FAIL job_idle c+%0d gnt/en/valid/busy/err got %b want 0", c - t, {obs, rsp_err});
            end
         end
      end
      pe_inj = 1'b0;
      ptr_m  = (o + 1) % N;
   endtask

   task automatic test_reset();
      logic [13:0] snap;
      rst = 1'b1; req = '1; rsp_ready = 1'b1; pe_inj = 1'b0;
      repeat (3) begin
         step();
         snap = {gnt, sel, pass_idx, pe_en, rsp_valid, rsp_id, rsp_err, busy};
         vectors++;
         if (snap !== '0) begin
            miscompares++;
            $display("FAIL reset_state got %b want 0", snap);
         end
      end
      rst = 1'b0;
      step();
      vectors++;
      if ({gnt, pe_en, sel} !== {4'b0001, 1'b1, 2'd0}) begin
         miscompares++;
         $display("FAIL reset_first_grant gnt/en/sel got %b/%b/%0d want 0001/1/0", gnt, pe_en, sel);
      end
      rst = 1'b1;
      step();
      rst = 1'b0; req = '0;
      vectors++;
      if ({gnt, pe_en, busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_abort gnt/en/busy got %b want 0", {gnt, pe_en, busy});
      end
      step();
      ptr_m = 0;
   endtask

   task automatic test_fairness();
      int exp_ids[5] = '{0, 1, 2, 3, 0};
      int jobs, last_h;
      jobs = 0; last_h = -1;
      pe_lat = 7; rsp_ready = 1'b1; req = '1;
      for (int i = 0; i < 300 && jobs < 5; i++) begin
         step();
         if (pe_en && pass_idx == '0 && last_h >= 0) begin
            vectors++;
            if (cyc !== last_h + 2) begin
               miscompares++;
               $display("FAIL fair_gap pe_en at h+%0d want h+2", cyc - last_h);
            end
         end
         if (rsp_valid && rsp_ready) begin
            vectors++;
            if (rsp_id !== SW'(exp_ids[jobs])) begin
               miscompares++;
               $display("FAIL fair_order job %0d got id %0d want %0d", jobs, rsp_id, exp_ids[jobs]);
            end
            ptr_m  = (exp_ids[jobs] + 1) % N;
            last_h = cyc;
            jobs++;
         end
      end
      req = '0;
      vectors++;
      if (jobs != 5) begin
         miscompares++;
         $display("FAIL fair_timeout got %0d jobs want 5", jobs);
      end
      step(); step();
   endtask

   task automatic test_reset_mid();
      logic [13:0] snap;
      run_job(4'b0010, 7, 0, 1'b0, 1'b0);   // leaves the pointer at 2
      pe_lat = 7; req = 4'b0001;
      for (int c = 0; c < 11; c++) step();  // WAIT of pass 1
      vectors++;
      if ({pass_idx, busy, pe_en} !== {2'd1, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL mid_pre pass/busy/en got %0d/%b/%b want 1/1/0", pass_idx, busy, pe_en);
      end
      rst = 1'b1;
      step();
      rst = 1'b0; req = '0;
      snap = {gnt, sel, pass_idx, pe_en, rsp_valid, rsp_id, rsp_err, busy};
      vectors++;
      if (snap !== '0) begin
         miscompares++;
         $display("FAIL mid_reset got %b want 0", snap);
      end
      step();
      ptr_m = 0;
      run_job(4'b0101, 7, 0, 1'b0, 1'b0);   // pick 0 only if the pointer was cleared
      run_job(4'b0100, 7, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_job(N'($urandom_range(1, 15)), $urandom_range(1, 10), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

`ifdef PE_TIMEOUT_EN
   task automatic test_timeout();
      int o, t, first, extra;
      logic e_err;
      logic [SW-1:0] e_id;
      pe_mute = 1'b1; rsp_ready = 1'b1; req = 4'b0001;
      o = rr_pick(4'b0001, ptr_m);
      t = cyc; first = -1; extra = 0; e_err = 1'b0; e_id = '0;
      for (int c = t + 1; c <= t + 45 && first < 0; c++) begin
         step();
         if (pe_en && c != t + 1) extra++;
         if (rsp_valid) begin
            first = c; e_err = rsp_err; e_id = rsp_id;
         end
      end
      req = '0;
      vectors++;
      if (first != t + 34 || extra != 0) begin
         miscompares++;
         $display("FAIL timeout_when rsp at en+%0d extra_en %0d want en+33/0", first - t - 1, extra);
      end
      vectors++;
      if ({e_err, e_id} !== {1'b1, SW'(o)}) begin
         miscompares++;
         $display("FAIL timeout_rsp err/id got %b/%0d want 1/%0d", e_err, e_id, o);
      end
      pe_mute = 1'b0;
      ptr_m = (o + 1) % N;
      step(); step();
      run_job(4'b0010, 7, 0, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = '0; rsp_ready = 1'b1; pe_inj = 1'b0;
      test_reset();
      test_fairness();
      run_job(4'b0001, 7, 0, 1'b0, 1'b0);   // single job, 7-cycle PE
      run_job(4'b0010, 7, 5, 1'b0, 1'b0);   // backpressure: handshake on the 6th RESP cycle
      run_job(4'b1000, 7, 3, 1'b1, 1'b1);   // spurious done plus the owner dropping req
      test_reset_mid();
      test_random();
`ifdef PE_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
